// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DEF_DATASIZE  = 8;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter. The arbiter is the slave
// (consumes requests, drives the FIFO write port); the environment is master.
interface fifo_wr_arbiter_if #(
  parameter int DATASIZE = fifo_arb_pkg::DEF_DATASIZE,
  parameter int NREQ     = fifo_arb_pkg::DEF_NREQ,
  parameter int CNT_W    = fifo_arb_pkg::DEF_CNT_W
);
  logic                          en;
  logic [NREQ-1:0]               req;
  logic [NREQ-1:0][DATASIZE-1:0] req_data;  // slice i == bits [i*DATASIZE +: DATASIZE]
  logic                          wfull;
  logic [NREQ-1:0]               gnt;
  logic [NREQ-1:0]               ack;
  logic                          w_inc;
  logic [DATASIZE-1:0]           wdata;
  logic                          busy;
  logic [CNT_W-1:0]              wr_count;

  modport slave (
    input  en, req, req_data, wfull,
    output gnt, ack, w_inc, wdata, busy, wr_count
  );

  modport master (
    output en, req, req_data, wfull,
    input  gnt, ack, w_inc, wdata, busy, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin pick: first requester strictly after rr_ptr (circular) with req high.
module rr_picker #(
  parameter int NREQ  = fifo_arb_pkg::DEF_NREQ,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the farthest offset down so the nearest hit after rr_ptr wins.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      int j;
      j = (int'(rr_ptr_i) + k) % NREQ;
      if (req_i[j]) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: shares one write port among NREQ
// requesters with round-robin grants, bounded bursts, no bubble on handover,
// and a stall on wfull that neither drops nor repeats words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATASIZE  = DEF_DATASIZE,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              w_clk,
  input  logic              w_rst,   // async, active low
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic              in_burst;
  logic              granted_req;
  logic              accept;
  logic              burst_last;
  logic              burst_end;
  logic [DATASIZE-1:0] wdata_c;

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .vld_o    (pick_vld),
    .idx_o    (pick_idx)
  );

  assign pick_oh     = NREQ'(1) << pick_idx;
  assign in_burst    = (state_q == BURST);
  assign granted_req = |(gnt_q & bus.req);
  assign accept      = in_burst & granted_req & ~bus.wfull;
  // A burst closes on its last accepted word, or at once if the owner withdraws.
  assign burst_last  = accept & (burst_cnt_q == BC_W'(MAX_BURST - 1));
  assign burst_end   = burst_last | (in_burst & ~granted_req);

  // Data mux from the one-hot grant; zero when nothing is granted.
  always_comb begin
    wdata_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wdata_c = wdata_c | bus.req_data[i];
    end
  end

  assign bus.w_inc    = accept;
  assign bus.ack      = in_burst ? (gnt_q & bus.req & {NREQ{~bus.wfull}}) : '0;
  assign bus.wdata    = wdata_c;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = in_burst;
  assign bus.wr_count = wr_count_q;

  // Next-state: grant from IDLE, count accepts, re-arbitrate on burst end.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      IDLE: begin
        if (bus.en && pick_vld) begin
          state_d     = BURST;
          gnt_d       = pick_oh;
          rr_ptr_d    = pick_idx;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          wr_count_d  = wr_count_q + 1'b1;
        end
        if (burst_end) begin
          // Handover on the same edge keeps the write port busy back-to-back.
          if (bus.en && pick_vld) begin
            gnt_d       = pick_oh;
            rr_ptr_d    = pick_idx;
            burst_cnt_d = '0;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            burst_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; rr_ptr resets to the top index so requester 0 wins first.
  always_ff @(posedge w_clk or negedge w_rst) begin
    if (!w_rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= IDX_W'(NREQ - 1);
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle table for the wfull stall plus
// requester-model sequences with an expected-word scoreboard.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int CW = 16;

  logic w_clk;
  logic w_rst;

  fifo_wr_arbiter_if #(.DATASIZE(DW), .NREQ(NR), .CNT_W(CW)) bus ();

  fifo_wr_arbiter #(.DATASIZE(DW), .NREQ(NR), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [NR-1:0] req;
    logic          wfull;
    logic          en;
    logic [DW-1:0] d1;
    logic [NR-1:0] e_gnt;
    logic          e_winc;
    logic [NR-1:0] e_ack;
    logic          e_busy;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t vecs [10];

  int n_tests = 0;
  int n_fail  = 0;

  // requester model
  int            remaining [NR];
  logic [DW-1:0] nextd     [NR];
  logic          en_v;
  logic          wfull_v;
  logic [DW-1:0] exp_q [$];

  // per-cycle samples and scenario stats
  logic [NR-1:0] s_gnt;
  logic          s_winc;
  logic          s_busy;
  int cyc, first_w, last_w, n_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_scn();
    cyc = 0; first_w = -1; last_w = -1; n_w = 0;
  endtask

  task automatic apply_reset();
    w_rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 0;
      nextd[i]     = '0;
    end
    bus.req      = '0;
    bus.req_data = '0;
    en_v         = 1'b1;
    wfull_v      = 1'b0;
    bus.en       = 1'b1;
    bus.wfull    = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge w_clk);
    #1 w_rst = 1'b1;
    start_scn();
  endtask

  // One clock: drive from the model at edge+1, sample at edge+4, advance acked words.
  task automatic cycle();
    logic [DW-1:0] e;
    for (int i = 0; i < NR; i++) begin
      bus.req[i]      = (remaining[i] > 0);
      bus.req_data[i] = nextd[i];
    end
    bus.en    = en_v;
    bus.wfull = wfull_v;
    #3;
    s_gnt  = bus.gnt;
    s_winc = bus.w_inc;
    s_busy = bus.busy;
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
    if (s_winc) begin
      chk("ack_onehot", 32'($countones(bus.ack)), 1);
      if (first_w < 0) first_w = cyc;
      last_w = cyc;
      n_w++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got %0h expected none", bus.wdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wdata", bus.wdata, e);
      end
    end else begin
      chk("ack_no_write", bus.ack, 0);
    end
    for (int i = 0; i < NR; i++) begin
      if (bus.ack[i]) begin
        nextd[i]     = nextd[i] + 8'd1;
        remaining[i] = remaining[i] - 1;
      end
    end
    cyc++;
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    // Stall table: requester 1, two words, three wfull cycles, two words, withdraw.
    vecs[0] = '{4'b0010, 1'b0, 1'b1, 8'h51, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[1] = '{4'b0010, 1'b0, 1'b1, 8'h51, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h51};
    vecs[2] = '{4'b0010, 1'b0, 1'b1, 8'h52, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h52};
    vecs[3] = '{4'b0010, 1'b1, 1'b1, 8'h53, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h53};
    vecs[4] = '{4'b0010, 1'b1, 1'b1, 8'h53, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h53};
    vecs[5] = '{4'b0010, 1'b1, 1'b1, 8'h53, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h53};
    vecs[6] = '{4'b0010, 1'b0, 1'b1, 8'h53, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h53};
    vecs[7] = '{4'b0010, 1'b0, 1'b1, 8'h54, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h54};
    vecs[8] = '{4'b0000, 1'b0, 1'b1, 8'h55, 4'b0010, 1'b0, 4'b0000, 1'b1, 8'h55};
    vecs[9] = '{4'b0000, 1'b0, 1'b1, 8'h55, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};

    // ---- reset held with all requesting
    w_rst        = 1'b0;
    bus.en       = 1'b1;
    bus.wfull    = 1'b0;
    bus.req      = 4'b1111;
    bus.req_data = '0;
    @(posedge w_clk);
    @(posedge w_clk);
    #2;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_winc", bus.w_inc, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wrcount", bus.wr_count, 0);
    chk("rst_wdata", bus.wdata, 0);
    w_rst = 1'b1;
    @(posedge w_clk);
    #2;
    chk("first_gnt", bus.gnt, 4'b0001);
    chk("first_busy", bus.busy, 1);

    // ---- table: wfull stall
    apply_reset();
    for (int r = 0; r < 10; r++) begin
      bus.req      = vecs[r].req;
      bus.wfull    = vecs[r].wfull;
      bus.en       = vecs[r].en;
      bus.req_data = {NR{8'hEE}};
      bus.req_data[1] = vecs[r].d1;
      #3;
      chk($sformatf("tbl%0d_gnt", r),   bus.gnt,   vecs[r].e_gnt);
      chk($sformatf("tbl%0d_winc", r),  bus.w_inc, vecs[r].e_winc);
      chk($sformatf("tbl%0d_ack", r),   bus.ack,   vecs[r].e_ack);
      chk($sformatf("tbl%0d_busy", r),  bus.busy,  vecs[r].e_busy);
      chk($sformatf("tbl%0d_wdata", r), bus.wdata, vecs[r].e_wdata);
      @(posedge w_clk);
      #1;
    end
    #3 chk("tbl_wrcount", bus.wr_count, 4);

    // ---- single requester, 12 words, regrant to itself without bubble
    apply_reset();
    remaining[2] = 12;
    nextd[2]     = 8'h10;
    for (int k = 0; k < 12; k++) exp_q.push_back(8'(8'h10 + k));
    cycle();
    chk("single_c0_gnt", s_gnt, 0);
    cycle();
    chk("single_c1_gnt", s_gnt, 4'b0100);
    repeat (14) cycle();
    chk("single_first_w", first_w, 1);
    chk("single_span", last_w - first_w, 11);
    chk("single_nw", n_w, 12);
    chk("single_sb_empty", exp_q.size(), 0);
    chk("single_wrcount", bus.wr_count, 12);
    chk("single_idle_busy", s_busy, 0);

    // ---- round robin, all requesting, two bursts each
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      remaining[i] = 8;
      nextd[i]     = 8'(i * 32);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int k = 0; k < MB; k++) exp_q.push_back(8'(i * 32 + r * MB + k));
    repeat (36) cycle();
    chk("rr_first_w", first_w, 1);
    chk("rr_span", last_w - first_w, 31);
    chk("rr_nw", n_w, 32);
    chk("rr_sb_empty", exp_q.size(), 0);
    chk("rr_wrcount", bus.wr_count, 32);
    chk("rr_idle_busy", s_busy, 0);

    // ---- withdraw handover, then en low mid-burst
    apply_reset();
    remaining[0] = 1;  nextd[0] = 8'hA0;
    remaining[3] = 8;  nextd[3] = 8'hB0;
    exp_q.push_back(8'hA0);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'hB0 + k));
    cycle();                                    // c0 grant 0
    cycle();                                    // c1 A0
    chk("wd_c1_gnt", s_gnt, 4'b0001);
    cycle();                                    // c2 req0 gone
    chk("wd_c2_gnt", s_gnt, 4'b0001);
    chk("wd_c2_winc", s_winc, 0);
    cycle();                                    // c3 B0
    chk("wd_c3_gnt", s_gnt, 4'b1000);
    chk("wd_c3_winc", s_winc, 1);
    en_v = 1'b0;
    repeat (3) cycle();                         // c4..c6 B1..B3
    chk("en_c6_gnt", s_gnt, 4'b1000);
    cycle();                                    // c7
    chk("en_c7_gnt", s_gnt, 0);
    chk("en_c7_busy", s_busy, 0);
    cycle();
    chk("en_c8_winc", s_winc, 0);
    chk("en_sb_empty", exp_q.size(), 0);
    chk("en_wrcount", bus.wr_count, 5);

    // ---- async reset mid-burst
    apply_reset();
    remaining[1] = 6;
    nextd[1]     = 8'hC0;
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    repeat (3) cycle();
    chk("ar_sb_empty", exp_q.size(), 0);
    for (int i = 0; i < NR; i++) begin
      bus.req[i]      = (remaining[i] > 0);
      bus.req_data[i] = nextd[i];
    end
    #1 chk("ar_pre_winc", bus.w_inc, 1);
    w_rst = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt, 0);
    chk("ar_winc", bus.w_inc, 0);
    chk("ar_ack", bus.ack, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_wrcount", bus.wr_count, 0);
    @(posedge w_clk);
    #1 w_rst = 1'b1;
    start_scn();
    remaining[0] = 1;
    nextd[0]     = 8'hD0;
    exp_q.push_back(8'hD0);
    for (int k = 2; k < 6; k++) exp_q.push_back(8'(8'hC0 + k));
    cycle();
    cycle();
    chk("ar_regrant0", s_gnt, 4'b0001);
    repeat (8) cycle();
    chk("ar_sb_empty2", exp_q.size(), 0);
    chk("ar_wrcount2", bus.wr_count, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
